dsp: RTL and testbench
======================

Name: dsp

Overview:
- 8-lane, 32-bit vector arithmetic unit with four operations selected by `operation`:
  - lane-wise add
  - lane-wise subtract
  - lane-wise Q16.16 fixed-point multiply
  - 8-tap FIR-style convolution
- Operands are two 8-element arrays, captured on `start`. Results go to an 8-element registered output array.
- A one-cycle `done` pulse marks completion.
- Sits beside the core as a memory-mapped or coprocessor DSP accelerator.

Parameters:
- LANES, 8, number of vector elements / FIR taps (fixed at 8 for this block)
- WIDTH, 32, element width in bits
- FRAC, 16, fractional bits for the fixed-point multiply

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset (rst=0 resets on a rising clk edge)
- start  input  1  begin an operation; sampled only in IDLE
- operation  input  2  00=add, 01=multiply, 10=FIR, 11=subtract
- A  input  8 x 32 (unpacked array [7:0])  operand A / FIR coefficients h
- B  input  8 x 32 (unpacked array [7:0])  operand B / FIR signal samples x
- result  output  8 x 32 (unpacked array [7:0])  registered results
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, all result[i]=0, done=0, accumulators and tap counter cleared. Reset mid-operation aborts it; no done pulse is produced.
- FSM states and transitions:
  - IDLE: on start=1, latch A, B and operation into internal registers and clear accumulators. Go to EXEC. Otherwise stay.
  - EXEC, add/sub/mul: one cycle; write all result lanes, go to DONE.
  - EXEC, FIR: 8 cycles with tap counter j=0..7. Each cycle, for each lane k, acc[k] += A[j]*B[k+4-j]; the B term is 0 when k+4-j<0 or >7. After j=7, copy acc to result and go to DONE.
  - DONE: done=1 for exactly this cycle; next state IDLE.
- Latency, counting from the posedge that samples start:
  - add/sub/mul: done high during the 2nd following cycle.
  - FIR: done high during the 9th following cycle.
  - result is valid in the same cycle done is high.
- start outside IDLE (EXEC/DONE) is ignored. Input changes after capture do not affect the running operation.
- result holds its value until the next operation writes it. done=0 in all states except DONE.
- Arithmetic:
  - Add: result[i] = A[i]+B[i], modulo 2^32.
  - Subtract: result[i] = A[i]-B[i], modulo 2^32.
  - Multiply: signed 32x32 to 64-bit product, arithmetic shift right by FRAC, low 32 bits kept (truncation, no rounding, no saturation). Example: 0x10000*0x20000 gives 0x20000.
  - FIR: result[k] = sum over j=0..7 of A[j]*B[k+4-j], out-of-range B treated as 0. Plain integer products (no FRAC shift), low 32 bits kept, accumulation modulo 2^32.
  - FIR term coverage: result[0] uses j=0..4; result[3] and result[4] use all in-range taps; result[7] uses j=4..7.
- Unused `operation` encodings: none; all four are defined.

Test Plan:
- Add: A[i] = 0x10000 + i*0x20000, B[i] = 0x20000 + i*0x20000 (i.e. A = 0x10000, 0x30000, ... 0xF0000 and B = 0x20000, 0x40000, ... 0x100000), op=00. Required: result = 0x30000, 0x70000, 0xB0000, 0xF0000, 0x130000, 0x170000, 0x1B0000, 0x1F0000; done 2 cycles after start.
- Multiply: same operands, op=01. Required: result = 0x20000, 0xC0000, 0x1E0000, 0x380000, 0x5A0000, 0x840000, 0xB60000, 0xF00000.
- Subtract: A and B swapped from the add vectors (A[i]=B_add[i], B[i]=A_add[i]), op=11. Required: every result[i]=0x10000. Also A[0]=0, B[0]=1 gives 0xFFFFFFFF (wrap).
- FIR: A[j]=1 for all j, B[n]=n+1, op=10. Required: result = 15, 21, 28, 36, 35, 33, 30, 26; done 9 cycles after start.
- FIR with Q16.16-scale operands (the add vectors): every product is a multiple of 2^32. Required: all result[k]=0 (truncation check).
- Control:
  - start pulsed again during FIR EXEC: ignored, single done pulse.
  - rst=0 mid-FIR: result=0, done never asserts.
  - result holds after done until the next operation completes.

Source files
------------

// File: rtl/dsp_if.sv
// Operand/result bundle between a host and the dsp vector unit.
// The host drives start/operation/A/B; the unit returns result/done.
interface dsp_if #(
  parameter int LANES = 8,
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       operation;
  logic [WIDTH-1:0] A      [LANES-1:0];
  logic [WIDTH-1:0] B      [LANES-1:0];
  logic [WIDTH-1:0] result [LANES-1:0];
  logic             done;

  modport master (output start, operation, A, B, input result, done);
  modport slave  (input start, operation, A, B, output result, done);
endinterface

// File: rtl/dsp.sv
// 8-lane vector arithmetic unit: add, subtract, Q16.16 multiply and an 8-tap FIR.
// Operands are captured on start; a one-cycle done marks valid registered results.
module dsp #(
  parameter int LANES = 8,
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input logic  clk,
  input logic  rst,
  dsp_if.slave bus
);
  localparam int TAP_W = $clog2(LANES);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(LANES - 1);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_FIR = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  logic [TAP_W-1:0] r_tap;
  logic [WIDTH-1:0] r_a        [LANES-1:0];
  logic [WIDTH-1:0] r_b        [LANES-1:0];
  logic [WIDTH-1:0] r_acc      [LANES-1:0];
  logic [WIDTH-1:0] r_result   [LANES-1:0];
  logic [WIDTH-1:0] w_acc_next [LANES-1:0];
  logic [WIDTH-1:0] w_lane     [LANES-1:0];
  logic             w_done;

  // Signed Q16.16 product: full-width multiply, arithmetic shift, keep the low word.
  function automatic logic [WIDTH-1:0] q_mul(input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = a * b;
    return WIDTH'(p >>> FRAC);
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: give every always_comb output a default first, otherwise a latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_EXEC;
      S_EXEC:  if (r_op != OP_FIR || r_tap == LAST_TAP) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_done = (r_state == S_DONE);
  end

  // FIR tap j adds A[j]*B[k+4-j] into lane k; off-the-end samples contribute zero.
  always_comb begin
    int idx;
    idx = 0;
    for (int k = 0; k < LANES; k++) begin
      idx           = k + (LANES / 2) - int'(r_tap);
      w_acc_next[k] = r_acc[k];
      if (idx >= 0 && idx < LANES)
        w_acc_next[k] = r_acc[k] + r_a[r_tap] * r_b[idx[TAP_W-1:0]];
      w_lane[k] = w_acc_next[k];
      case (r_op)
        OP_ADD: w_lane[k] = r_a[k] + r_b[k];
        OP_SUB: w_lane[k] = r_a[k] - r_b[k];
        OP_MUL: w_lane[k] = q_mul(r_a[k], r_b[k]);
        OP_FIR: w_lane[k] = w_acc_next[k];
      endcase
    end
  end

  // NOTE: operand registers are only read after a capture, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.start) begin
      r_a  <= bus.A;
      r_b  <= bus.B;
      r_op <= op_e'(bus.operation);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tap <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_acc[k]    <= '0;
        r_result[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_tap <= '0;
            for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
          end
        end
        S_EXEC: begin
          r_acc <= w_acc_next;
          r_tap <= r_tap + 1'b1;
          if (r_op != OP_FIR || r_tap == LAST_TAP) r_result <= w_lane;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.done   = w_done;
endmodule

// File: tb/tb_dsp.sv
// Directed bench for dsp: a vector table of operations with hand-computed results,
// followed by control sequences for restart, reset abort and result hold.
module tb_dsp;
  logic clk;
  logic rst;

  dsp_if bus ();

  dsp u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a   [8];
    logic [31:0] b   [8];
    logic [31:0] exp [8];
    int          lat;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input int v);
    bus.operation = vecs[v].op;
    for (int i = 0; i < 8; i++) begin
      bus.A[i] = vecs[v].a[i];
      bus.B[i] = vecs[v].b[i];
    end
  endtask

  // Start vector v, then corrupt the inputs and count cycles until done is seen.
  task automatic run_vec(input int v, output int lat);
    @(negedge clk);
    drive_vec(v);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.operation = ~vecs[v].op;
    for (int i = 0; i < 8; i++) begin
      bus.A[i] = ~vecs[v].a[i];
      bus.B[i] = vecs[v].b[i] + 32'h1234;
    end
    lat = 1;
    while (!bus.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_lanes(input string name, input int v);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s.result[%0d]", name, i), bus.result[i], vecs[v].exp[i]);
  endtask

  initial begin
    int lat;
    int pulses;
    int first;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{name: "add", op: 2'b00, lat: 2,
      a:   '{32'h10000, 32'h30000, 32'h50000, 32'h70000, 32'h90000, 32'hB0000, 32'hD0000, 32'hF0000},
      b:   '{32'h20000, 32'h40000, 32'h60000, 32'h80000, 32'hA0000, 32'hC0000, 32'hE0000, 32'h100000},
      exp: '{32'h30000, 32'h70000, 32'hB0000, 32'hF0000, 32'h130000, 32'h170000, 32'h1B0000, 32'h1F0000}};
    vecs[1] = '{name: "mul", op: 2'b01, lat: 2,
      a:   '{32'h10000, 32'h30000, 32'h50000, 32'h70000, 32'h90000, 32'hB0000, 32'hD0000, 32'hF0000},
      b:   '{32'h20000, 32'h40000, 32'h60000, 32'h80000, 32'hA0000, 32'hC0000, 32'hE0000, 32'h100000},
      exp: '{32'h20000, 32'hC0000, 32'h1E0000, 32'h380000, 32'h5A0000, 32'h840000, 32'hB60000, 32'hF00000}};
    vecs[2] = '{name: "sub", op: 2'b11, lat: 2,
      a:   '{32'h20000, 32'h40000, 32'h60000, 32'h80000, 32'hA0000, 32'hC0000, 32'hE0000, 32'h100000},
      b:   '{32'h10000, 32'h30000, 32'h50000, 32'h70000, 32'h90000, 32'hB0000, 32'hD0000, 32'hF0000},
      exp: '{default: 32'h10000}};
    vecs[3] = '{name: "sub_wrap", op: 2'b11, lat: 2,
      a:   '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7},
      b:   '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
      exp: '{default: 32'hFFFFFFFF}};
    vecs[4] = '{name: "mul_signed", op: 2'b01, lat: 2,
      a:   '{32'hFFFE8000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00018000,
             32'h3, 32'h10000, 32'hFFFF0000, 32'h0},
      b:   '{32'h20000, 32'h8000, 32'h20000, 32'h00018000,
             32'h5, 32'h10000, 32'hFFFF0000, 32'hDEADBEEF},
      exp: '{32'hFFFD0000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00024000,
             32'h0, 32'h10000, 32'h10000, 32'h0}};
    vecs[5] = '{name: "fir", op: 2'b10, lat: 9,
      a:   '{default: 32'd1},
      b:   '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
      exp: '{32'd15, 32'd21, 32'd28, 32'd36, 32'd35, 32'd33, 32'd30, 32'd26}};
    vecs[6] = '{name: "fir_q16", op: 2'b10, lat: 9,
      a:   '{32'h10000, 32'h30000, 32'h50000, 32'h70000, 32'h90000, 32'hB0000, 32'hD0000, 32'hF0000},
      b:   '{32'h20000, 32'h40000, 32'h60000, 32'h80000, 32'hA0000, 32'hC0000, 32'hE0000, 32'h100000},
      exp: '{default: 32'h0}};
    vecs[7] = '{name: "fir_edges", op: 2'b10, lat: 9,
      a:   '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
      b:   '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1},
      exp: '{32'd5, 32'd6, 32'd7, 32'd9, 32'd2, 32'd3, 32'd4, 32'd5}};

    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.operation = 2'b00;
    for (int i = 0; i < 8; i++) begin
      bus.A[i] = '0;
      bus.B[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("reset.done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("reset.result[%0d]", i), bus.result[i], 32'd0);

    for (int v = 0; v < NVEC; v++) begin
      run_vec(v, lat);
      check($sformatf("%s.latency", vecs[v].name), 32'(lat), 32'(vecs[v].lat));
      check_lanes(vecs[v].name, v);
      @(negedge clk);
      check($sformatf("%s.done_pulse", vecs[v].name), 32'(bus.done), 32'd0);
    end

    // Second start during FIR execution must be ignored.
    @(negedge clk);
    drive_vec(5);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        drive_vec(0);
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        pulses++;
        if (first == 0) first = c;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("restart.pulses", 32'(pulses), 32'd1);
    check("restart.latency", 32'(first), 32'd9);
    check_lanes("restart_hold", 5);

    // Result holds through the next operation until it completes.
    run_vec(0, lat);
    check("hold_next.latency", 32'(lat), 32'd2);
    check_lanes("hold_next", 0);
    @(negedge clk);
    drive_vec(5);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("hold_exec.result[0]", bus.result[0], vecs[0].exp[0]);
    check("hold_exec.result[7]", bus.result[7], vecs[0].exp[7]);

    // Reset in the middle of a FIR aborts it without a done pulse.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.done) pulses++;
      @(negedge clk);
    end
    check("abort.pulses", 32'(pulses), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("abort.result[%0d]", i), bus.result[i], 32'd0);

    run_vec(1, lat);
    check("recover.latency", 32'(lat), 32'd2);
    check_lanes("recover", 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
